// File: rtl/sgd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgd_pkg
//  Brief    : Shared FSM encoding and timing constants for the SGD controller.
//  Revision : 1.0 - initial release
// ============================================================================
package sgd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned c_CHUNK_CYCLES = 3;

    // Cycles from the accepting start edge to the edge that raises done.
    function automatic int unsigned run_cycles(input int unsigned chunks,
                                               input int unsigned iters);
        return c_CHUNK_CYCLES * chunks * iters + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sgd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sgd_ctrl_if
//  Brief    : Control, weight-buffer and datapath signals of the SGD controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface sgd_ctrl_if #(
    parameter int INPUT_BITWIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ITER_WIDTH     = 16
) ();

    logic                      start;
    logic                      abort;
    logic [ADDR_WIDTH-1:0]     num_chunks;
    logic [ITER_WIDTH-1:0]     num_iters;
    logic [INPUT_BITWIDTH-1:0] mu_in;

    logic                      w_rd_en;
    logic [ADDR_WIDTH-1:0]     w_rd_addr;
    logic                      sgd_en;
    logic [INPUT_BITWIDTH-1:0] mu_out;
    logic                      w_wr_en;
    logic [ADDR_WIDTH-1:0]     w_wr_addr;
    logic [ITER_WIDTH-1:0]     iter_cnt;
    logic                      busy;
    logic                      done;

    // Controller side
    modport master (
        input  start, abort, num_chunks, num_iters, mu_in,
        output w_rd_en, w_rd_addr, sgd_en, mu_out, w_wr_en, w_wr_addr,
               iter_cnt, busy, done
    );

    // Host / buffer / datapath side
    modport slave (
        output start, abort, num_chunks, num_iters, mu_in,
        input  w_rd_en, w_rd_addr, sgd_en, mu_out, w_wr_en, w_wr_addr,
               iter_cnt, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/sgd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sgd_ctrl
//  Brief    : Sequences READ/LOAD/WRITE over all weight chunks for num_iters passes.
//  Revision : 1.0 - initial release
// ============================================================================
module sgd_ctrl
    import sgd_pkg::*;
#(
    parameter int INPUT_BITWIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ITER_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    sgd_ctrl_if.master  bus
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_num_chunks;
    logic [ITER_WIDTH-1:0]     r_num_iters;
    logic [INPUT_BITWIDTH-1:0] r_mu;
    logic [ADDR_WIDTH-1:0]     r_chunk;
    logic [ADDR_WIDTH-1:0]     w_chunk_nxt;
    logic [ITER_WIDTH-1:0]     r_iter;
    logic [ITER_WIDTH-1:0]     w_iter_nxt;
    logic [ADDR_WIDTH-1:0]     r_rd_hold;
    logic [ADDR_WIDTH-1:0]     r_wr_hold;
    logic                      r_done;

    logic w_accept;
    logic w_zero_run;
    logic w_last_chunk;
    logic w_last_iter;
    logic w_rd_en;
    logic w_wr_en;

    assign w_accept     = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_zero_run   = (bus.num_chunks == '0) || (bus.num_iters == '0);
    assign w_last_chunk = (r_chunk == r_num_chunks - ADDR_WIDTH'(1));
    assign w_last_iter  = (r_iter  == r_num_iters  - ITER_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_chunk_nxt = r_chunk;
        w_iter_nxt  = r_iter;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_chunk_nxt = '0;
                    w_iter_nxt  = '0;
                    w_state_nxt = w_zero_run ? DONE : READ;
                end
            end
            READ:  w_state_nxt = LOAD;
            LOAD:  w_state_nxt = WRITE;
            WRITE: begin
                if (!w_last_chunk) begin
                    w_chunk_nxt = r_chunk + ADDR_WIDTH'(1);
                    w_state_nxt = READ;
                end else if (!w_last_iter) begin
                    w_chunk_nxt = '0;
                    w_iter_nxt  = r_iter + ITER_WIDTH'(1);
                    w_state_nxt = READ;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Abort freezes the counters so iter_cnt reports where the run stopped.
        if (bus.abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_chunk_nxt = r_chunk;
            w_iter_nxt  = r_iter;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_chunks <= '0;
            r_num_iters  <= '0;
            r_mu         <= '0;
            r_chunk      <= '0;
            r_iter       <= '0;
            r_rd_hold    <= '0;
            r_wr_hold    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_chunk <= w_chunk_nxt;
            r_iter  <= w_iter_nxt;
            r_done  <= (r_state == DONE) && !bus.abort;
            if (w_accept) begin
                r_num_chunks <= bus.num_chunks;
                r_num_iters  <= bus.num_iters;
                r_mu         <= bus.mu_in;
            end
            if (w_rd_en) begin
                r_rd_hold <= r_chunk;
            end
            if (w_wr_en) begin
                r_wr_hold <= r_chunk;
            end
        end
    end

    // Strobes decode the state directly; addresses show the live chunk only while strobed.
    assign w_rd_en       = (r_state == READ);
    assign w_wr_en       = (r_state == WRITE) && !bus.abort;

    assign bus.w_rd_en   = w_rd_en;
    assign bus.w_rd_addr = w_rd_en ? r_chunk : r_rd_hold;
    assign bus.sgd_en    = (r_state == LOAD);
    assign bus.w_wr_en   = w_wr_en;
    assign bus.w_wr_addr = w_wr_en ? r_chunk : r_wr_hold;
    assign bus.mu_out    = r_mu;
    assign bus.iter_cnt  = r_iter;
    assign bus.busy      = (r_state == READ) || (r_state == LOAD) || (r_state == WRITE);
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sgd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sgd_ctrl
//  Brief    : Self-checking bench for sgd_ctrl against a cycle-indexed run model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sgd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sgd_ctrl_if bus ();

    sgd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int exp_mu   = 0;
    int exp_iter = 0;
    int last_rd  = 0;
    int last_wr  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph, input int e_rd, input int e_rda,
                                 input int e_sgd, input int e_wr, input int e_wra,
                                 input int e_busy, input int e_done);
        chk({ph, ".rd_en"},   32'(bus.w_rd_en),   e_rd);
        chk({ph, ".rd_addr"}, 32'(bus.w_rd_addr), e_rda);
        chk({ph, ".sgd_en"},  32'(bus.sgd_en),    e_sgd);
        chk({ph, ".wr_en"},   32'(bus.w_wr_en),   e_wr);
        chk({ph, ".wr_addr"}, 32'(bus.w_wr_addr), e_wra);
        chk({ph, ".busy"},    32'(bus.busy),      e_busy);
        chk({ph, ".done"},    32'(bus.done),      e_done);
        chk({ph, ".iter"},    32'(bus.iter_cnt),  exp_iter);
        chk({ph, ".mu"},      32'(bus.mu_out),    exp_mu);
    endtask

    // One run: the model indexes cycles j after the accepting edge. Step n = j/3 is
    // chunk n%C of pass n/C; phase 0/1/2 is read/capture/write-back. Done lands at j = 3CI+1.
    task automatic run(input int c, input int it, input int mu,
                       input int repulse_at, input int abort_at, input int rst_at);
        int  total;
        bit  dead;
        int  n, ph, ch;
        int  e_rd, e_rda, e_sgd, e_wr, e_wra, e_busy, e_done;
        total = 3 * c * it;
        dead  = 1'b0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_chunks = 8'(c);
        bus.num_iters  = 16'(it);
        bus.mu_in      = 8'(mu);
        @(posedge clk);
        exp_mu   = mu;
        exp_iter = 0;
        for (int j = 0; j <= total + 2; j++) begin
            @(negedge clk);
            bus.start = (j == repulse_at);
            if (j == repulse_at) begin
                bus.num_chunks = 8'($urandom_range(1, 9));
                bus.num_iters  = 16'($urandom_range(1, 9));
                bus.mu_in      = 8'($urandom);
            end
            bus.abort = (j == abort_at);
            rst       = (j == rst_at);
            #1;
            e_rd = 0; e_sgd = 0; e_wr = 0; e_busy = 0; e_done = 0;
            e_rda = last_rd; e_wra = last_wr;
            if (!dead && j < total) begin
                n        = j / 3;
                ph       = j % 3;
                ch       = n % c;
                exp_iter = n / c;
                e_busy   = 1;
                if (ph == 0) begin
                    e_rd = 1; e_rda = ch;
                end else if (ph == 1) begin
                    e_sgd = 1;
                end else if (j != abort_at) begin
                    e_wr = 1; e_wra = ch;
                end
            end else if (!dead && j == total + 1) begin
                e_done = 1;
            end
            check_outputs($sformatf("run%0dx%0d.j%0d", c, it, j),
                          e_rd, e_rda, e_sgd, e_wr, e_wra, e_busy, e_done);
            last_rd = e_rda;
            last_wr = e_wra;
            if (j == abort_at) dead = 1'b1;
            if (j == rst_at) begin
                dead     = 1'b1;
                exp_mu   = 0;
                exp_iter = 0;
                last_rd  = 0;
                last_wr  = 0;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, it, total, rp, ab;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_chunks = '0;
        bus.num_iters  = '0;
        bus.mu_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0);

        run(2, 1, 3, -1, -1, -1);
        run(3, 2, 17, -1, -1, -1);
        run(0, 5, 44, -1, -1, -1);
        run(3, 0, 45, -1, -1, -1);
        run(4, 1, 90, 5, -1, -1);
        run(4, 1, 91, -1, 5, -1);
        run(4, 1, 92, -1, -1, 1);
        run(4, 1, 93, -1, -1, -1);

        // start together with abort in IDLE must not launch a run
        @(negedge clk);
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        bus.num_chunks = 8'd2;
        bus.num_iters  = 16'd1;
        bus.mu_in      = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1;
        check_outputs("abort_start_idle", 0, last_rd, 0, 0, last_wr, 0, 0);

        for (int r = 0; r < 20; r++) begin
            c     = $urandom_range(0, 5);
            it    = $urandom_range(0, 3);
            total = 3 * c * it;
            rp    = -1;
            ab    = -1;
            if (total > 0 && $urandom_range(0, 1) == 1) rp = $urandom_range(0, total - 1);
            if (total > 0 && $urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, total - 1);
                if (rp >= ab) rp = -1;
            end
            run(c, it, int'($urandom_range(0, 255)), rp, ab, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sgd_ctrl.md
SGD_CTRL -- requirements
Module: sgd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  INPUT_BITWIDTH, 8, learning-rate (mu) width
  ADDR_WIDTH, 8, weight-buffer chunk address width
  ITER_WIDTH, 16, iteration counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all logic on posedge clk
  rst  input  1  synchronous reset, active-high
  start  input  1  one-cycle request to begin a run; sampled only in IDLE
  abort  input  1  terminate the current run
  num_chunks  input  ADDR_WIDTH  number of SIZE-wide weight chunks in the buffer
  num_iters  input  ITER_WIDTH  number of passes over all chunks
  mu_in  input  INPUT_BITWIDTH  learning rate for the run
  w_rd_en  output  1  weight-buffer read strobe
  w_rd_addr  output  ADDR_WIDTH  chunk read address
  sgd_en  output  1  datapath capture enable; read data is valid this cycle
  mu_out  output  INPUT_BITWIDTH  learning rate driven to the sgd datapath
  w_wr_en  output  1  write-back strobe for the registered datapath result
  w_wr_addr  output  ADDR_WIDTH  chunk write-back address
  iter_cnt  output  ITER_WIDTH  index of the current pass
  busy  output  1  run in progress
  done  output  1  one-cycle pulse on normal completion

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, READ, LOAD, WRITE, DONE.
REQ-004 In IDLE with start=1, the block SHALL latch num_chunks, num_iters and mu_in, clear the chunk and iteration counters, and go to READ; if either latched count is 0 it SHALL go directly to DONE.
REQ-005 In READ, the block SHALL assert w_rd_en=1 with w_rd_addr equal to the current chunk, then go to LOAD.
REQ-006 LOAD: the buffer has 1-cycle read latency; the block SHALL assert sgd_en=1, then go to WRITE.
REQ-007 WRITE: the datapath output is registered (1 cycle); the block SHALL assert w_wr_en=1 with w_wr_addr equal to the current chunk.
REQ-008 From WRITE, the chunk and iteration counters SHALL be updated as follows:
  - chunk < num_chunks-1: increment chunk, go to READ.
  - last chunk, iter_cnt < num_iters-1: wrap chunk to 0, increment iter_cnt, go to READ.
  - otherwise: go to DONE.
REQ-009 Each chunk SHALL cost exactly 3 cycles, so a run SHALL take 3*num_chunks*num_iters cycles plus the DONE cycle.
REQ-010 If start is sampled at edge k, done SHALL be high in the cycle following edge k+1+3*C*I, and only for that cycle; after DONE the FSM SHALL return to IDLE.
REQ-011 busy SHALL be 1 in READ, LOAD and WRITE, and 0 in IDLE and DONE.
REQ-012 start asserted while not in IDLE SHALL be ignored, and the latched parameters SHALL NOT change during a run.
REQ-013 mu_out SHALL hold the latched mu for the whole run, and its value SHALL be retained in IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; when abort and a WRITE-state w_wr_en coincide, the write SHALL be suppressed.
REQ-015 When abort and start are asserted together in IDLE, start SHALL be ignored.
REQ-016 Address outputs SHALL hold their last value when their strobe is low.
REQ-017 Counter widths SHALL match the port widths, and the counters SHALL never exceed the latched limits.

Reset
REQ-018 rst=1 at any clock edge, including mid-run, SHALL force IDLE and set all of the following to 0 at that edge: w_rd_en, w_wr_en, sgd_en, busy, done, w_rd_addr, w_wr_addr, iter_cnt, mu_out and all latched registers.
REQ-019 Reset SHALL take priority over abort and start.

Structure
REQ-020 The state encoding typedef and the per-chunk cycle-count constant (3) SHALL live in the shared package sgd_pkg.
REQ-021 The block SHALL be one module containing the FSM, the chunk/iteration counters and the parameter latches.
REQ-022 The block SHALL NOT instantiate the sgd datapath; integration SHALL be done at the parent level.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  - C=2, I=1, mu=3: rd addrs 0,1 and wr addrs 0,1; each chunk follows the READ, LOAD, WRITE order; done exactly 7 cycles after the start edge; mu_out=3 throughout.
  - C=3, I=2: wr address sequence 0,1,2,0,1,2; iter_cnt steps 0 then 1 after the third write; total 18 busy cycles.
  - C=0 or I=0: done one cycle after start; no rd/wr strobes; busy never 1.
  - C=4, I=1 with start re-pulsed mid-run: ignored; sequence unchanged.
  - C=4, I=1 with abort asserted in a WRITE cycle of chunk 1: w_wr_en stays 0 that cycle; IDLE next; no done.
  - C=4, I=1 with rst raised in LOAD: all outputs 0 next cycle; a new start then runs cleanly from chunk 0.
